// File: rtl/alu_pkg.sv
// Shared definitions for the RV32I ALU decode stage: op codes, opcode/funct7
// constants and the decoded-entry payload.
package alu_pkg;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned OP_W  = 5;
    localparam int unsigned REG_W = 5;
    localparam int unsigned IMM_W = 12;

    localparam logic [OP_W-1:0] ALU_ADD   = 5'd0;
    localparam logic [OP_W-1:0] ALU_SUB   = 5'd1;
    localparam logic [OP_W-1:0] ALU_SLL   = 5'd2;
    localparam logic [OP_W-1:0] ALU_SLT   = 5'd3;
    localparam logic [OP_W-1:0] ALU_SLTU  = 5'd4;
    localparam logic [OP_W-1:0] ALU_XOR   = 5'd5;
    localparam logic [OP_W-1:0] ALU_SRL   = 5'd6;
    localparam logic [OP_W-1:0] ALU_SRA   = 5'd7;
    localparam logic [OP_W-1:0] ALU_OR    = 5'd8;
    localparam logic [OP_W-1:0] ALU_AND   = 5'd9;
    localparam logic [OP_W-1:0] ALU_ADDI  = 5'd10;
    localparam logic [OP_W-1:0] ALU_SLLI  = 5'd11;
    localparam logic [OP_W-1:0] ALU_SLTI  = 5'd12;
    localparam logic [OP_W-1:0] ALU_SLTUI = 5'd13;
    localparam logic [OP_W-1:0] ALU_XORI  = 5'd14;
    localparam logic [OP_W-1:0] ALU_SRLI  = 5'd15;
    localparam logic [OP_W-1:0] ALU_SRAI  = 5'd16;
    localparam logic [OP_W-1:0] ALU_ORI   = 5'd17;
    localparam logic [OP_W-1:0] ALU_ANDI  = 5'd18;

    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] F7_ZERO = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef struct packed {
        logic [OP_W-1:0]  alu_op;
        logic [REG_W-1:0] rs1;
        logic [REG_W-1:0] rs2;
        logic [REG_W-1:0] rd;
        logic [IMM_W-1:0] imm;
        logic             wb_en;
        logic             illegal;
    } dec_entry_t;

endpackage

// File: rtl/alu_decode_logic.sv
// Combinational decode of one RV32I R-type / I-type ALU instruction into a
// buffer entry plus a legal flag.
module alu_decode_logic
    import alu_pkg::*;
(
    input  logic [XLEN-1:0] instr,
    output dec_entry_t      entry,
    output logic            legal
);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    assign funct7 = instr[31:25];

    always_comb begin
        entry         = '0;
        legal         = 1'b0;
        entry.rs1     = instr[19:15];
        entry.rd      = instr[11:7];
        if (opcode == OP_R) begin
            entry.rs2 = instr[24:20];
            if (funct7 == F7_ZERO) begin
                legal = 1'b1;
                case (funct3)
                    3'b000:  entry.alu_op = ALU_ADD;
                    3'b001:  entry.alu_op = ALU_SLL;
                    3'b010:  entry.alu_op = ALU_SLT;
                    3'b011:  entry.alu_op = ALU_SLTU;
                    3'b100:  entry.alu_op = ALU_XOR;
                    3'b101:  entry.alu_op = ALU_SRL;
                    3'b110:  entry.alu_op = ALU_OR;
                    default: entry.alu_op = ALU_AND;
                endcase
            end else if (funct7 == F7_ALT) begin
                if (funct3 == 3'b000) begin
                    legal        = 1'b1;
                    entry.alu_op = ALU_SUB;
                end else if (funct3 == 3'b101) begin
                    legal        = 1'b1;
                    entry.alu_op = ALU_SRA;
                end
            end
        end else if (opcode == OP_I) begin
            entry.imm = instr[31:20];
            legal     = 1'b1;
            case (funct3)
                3'b000:  entry.alu_op = ALU_ADDI;
                3'b010:  entry.alu_op = ALU_SLTI;
                3'b011:  entry.alu_op = ALU_SLTUI;
                3'b100:  entry.alu_op = ALU_XORI;
                3'b110:  entry.alu_op = ALU_ORI;
                3'b111:  entry.alu_op = ALU_ANDI;
                3'b001: begin
                    legal        = (funct7 == F7_ZERO);
                    entry.alu_op = ALU_SLLI;
                end
                default: begin
                    legal        = (funct7 == F7_ZERO) || (funct7 == F7_ALT);
                    entry.alu_op = (funct7 == F7_ALT) ? ALU_SRAI : ALU_SRLI;
                end
            endcase
        end

        // Unsupported encodings carry no operation and never write back.
        if (!legal) begin
            entry.alu_op = ALU_ADD;
            entry.rs2    = '0;
            entry.imm    = '0;
        end
        entry.wb_en   = legal && (entry.rd != '0);
        entry.illegal = !legal;
    end

endmodule

// File: rtl/alu_decode.sv
// Decode/issue stage: decoder followed by a 2-entry FIFO skid buffer.
// Optional feature macro: ALU_DEC_ILLEGAL_EN (deliver unsupported encodings flagged illegal).
module alu_decode
    import alu_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic [XLEN-1:0]   instr,
    input  logic              instr_valid,
    output logic              instr_ready,
    output logic              dec_valid,
    input  logic              dec_ready,
    output logic [OP_W-1:0]   alu_op,
    output logic [REG_W-1:0]  rs1_addr,
    output logic [REG_W-1:0]  rs2_addr,
    output logic [REG_W-1:0]  rd_addr,
    output logic [IMM_W-1:0]  imm,
    output logic              wb_en,
    output logic              illegal
);

    if (DEPTH != 2) begin : g_depth_check
        $error("alu_decode supports DEPTH == 2 only");
    end

    typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_e;

    state_e     state_q, state_d;
    dec_entry_t slot0_q, slot0_d;
    dec_entry_t slot1_q, slot1_d;
    logic       dec_valid_q, dec_valid_d;
    logic       instr_ready_q, instr_ready_d;

    dec_entry_t dec_entry;
    dec_entry_t new_entry;
    logic       dec_legal;
    logic       push;
    logic       pop;

    alu_decode_logic u_logic (
        .instr (instr),
        .entry (dec_entry),
        .legal (dec_legal)
    );

    // Next-state: occupancy FSM and slot shifting; slot0 is always the head.
    always_comb begin
        state_d   = state_q;
        slot0_d   = slot0_q;
        slot1_d   = slot1_q;
        new_entry = dec_entry;
`ifdef ALU_DEC_ILLEGAL_EN
        new_entry.illegal = !dec_legal;
        push = instr_valid && instr_ready_q && !flush;
`else
        new_entry.illegal = 1'b0;
        push = instr_valid && instr_ready_q && !flush && dec_legal;
`endif
        pop = dec_valid_q && dec_ready;

        if (flush) begin
            state_d = EMPTY;
            slot0_d = '0;
            slot1_d = '0;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (push) begin
                        slot0_d = new_entry;
                        state_d = ONE;
                    end
                end
                ONE: begin
                    case ({push, pop})
                        2'b10: begin
                            slot1_d = new_entry;
                            state_d = FULL;
                        end
                        2'b01: begin
                            slot0_d = '0;
                            state_d = EMPTY;
                        end
                        2'b11:   slot0_d = new_entry;
                        default: state_d = ONE;
                    endcase
                end
                FULL: begin
                    if (pop) begin
                        slot0_d = slot1_q;
                        slot1_d = '0;
                        state_d = ONE;
                    end
                end
                default: begin
                    state_d = EMPTY;
                    slot0_d = '0;
                    slot1_d = '0;
                end
            endcase
        end

        dec_valid_d   = (state_d != EMPTY);
        instr_ready_d = (state_d != FULL);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= EMPTY;
            slot0_q       <= '0;
            slot1_q       <= '0;
            dec_valid_q   <= 1'b0;
            instr_ready_q <= 1'b1;
        end else begin
            state_q       <= state_d;
            slot0_q       <= slot0_d;
            slot1_q       <= slot1_d;
            dec_valid_q   <= dec_valid_d;
            instr_ready_q <= instr_ready_d;
        end
    end

    assign instr_ready = instr_ready_q;
    assign dec_valid   = dec_valid_q;
    assign alu_op      = slot0_q.alu_op;
    assign rs1_addr    = slot0_q.rs1;
    assign rs2_addr    = slot0_q.rs2;
    assign rd_addr     = slot0_q.rd;
    assign imm         = slot0_q.imm;
    assign wb_en       = slot0_q.wb_en;
    assign illegal     = slot0_q.illegal;

endmodule
